// File: rtl/stream_pkg.sv
// Shared types and default widths for the narrow-to-wide stream upsizer.
package stream_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DATA_RATIO = 4;
  localparam int DEF_OUT_DEPTH  = 4;

  localparam int LANE_IDX_W = $clog2(DEF_DATA_RATIO);
  localparam int FILL_W     = $clog2(DEF_OUT_DEPTH + 1);

  typedef struct packed {
    logic [DEF_DATA_RATIO-1:0][DEF_DATA_WIDTH-1:0] lanes;
    logic [DEF_DATA_RATIO-1:0]                     keep;
    logic                                          last;
  } beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

  // Flattened width of one beat: lanes, keep mask and last flag.
  function automatic int beat_bits(input int ratio, input int width);
    return ratio * width + ratio + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Generic first-word-fall-through register FIFO; rdata reads as zero while empty.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = empty ? '0 : mem_r[rptr_r];

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

endmodule

// File: rtl/stream_upsize_pack.sv
// Packs narrow stream words into wide beats queued in an output FIFO.
// Optional idle-timeout flush of a partial beat: define STREAM_UPSIZE_FLUSH_EN.
module stream_upsize_pack
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int T_DATA_RATIO   = DEF_DATA_RATIO,
  parameter int OUT_DEPTH      = DEF_OUT_DEPTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [T_DATA_WIDTH-1:0]                   s_data_i,
  input  logic                                      s_last_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  output logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_DATA_RATIO-1:0]                   m_keep_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i,
  output logic [$clog2(OUT_DEPTH+1)-1:0]            fill_level_o
);

  localparam int IDX_W  = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
  localparam int BEAT_W = beat_bits(T_DATA_RATIO, T_DATA_WIDTH);

  typedef logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] lanes_t;

  if (T_DATA_RATIO < 2 || OUT_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("stream_upsize_pack: unsupported parameter set");
  end

  pack_state_e             state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  lanes_t                  lanes_r, lanes_s, lanes_cur_s;
  logic [T_DATA_RATIO-1:0] keep_r, keep_s, keep_cur_s;
  logic                    accept_s;
  logic                    flush_s;
  logic                    push_s;
  logic [BEAT_W-1:0]       push_data_s;
  logic [BEAT_W-1:0]       rdata_s;
  logic                    full_s;
  logic                    empty_s;

  assign s_ready_o = !full_s;
  assign m_valid_o = !empty_s;
  assign accept_s  = s_valid_i && s_ready_o;
  assign {m_data_o, m_keep_o, m_last_o} = rdata_s;

  // Packer next state: an accepted word always wins over a timeout flush.
  always_comb begin
    lanes_cur_s         = lanes_r;
    keep_cur_s          = keep_r;
    lanes_cur_s[idx_r]  = s_data_i;
    keep_cur_s[idx_r]   = 1'b1;
    state_s             = state_r;
    idx_s               = idx_r;
    lanes_s             = lanes_r;
    keep_s              = keep_r;
    push_s              = 1'b0;
    push_data_s         = {lanes_r, keep_r, 1'b0};
    if (accept_s) begin
      if (idx_r == IDX_W'(T_DATA_RATIO - 1) || s_last_i) begin
        push_s      = 1'b1;
        push_data_s = {lanes_cur_s, keep_cur_s, s_last_i};
        state_s     = IDLE;
        idx_s       = '0;
        lanes_s     = '0;
        keep_s      = '0;
      end else begin
        state_s = FILL;
        idx_s   = idx_r + IDX_W'(1);
        lanes_s = lanes_cur_s;
        keep_s  = keep_cur_s;
      end
    end else if (flush_s) begin
      push_s  = 1'b1;
      state_s = IDLE;
      idx_s   = '0;
      lanes_s = '0;
      keep_s  = '0;
    end else begin
      state_s = state_r;
    end
  end

  // Packer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      lanes_r <= '0;
      keep_r  <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      lanes_r <= lanes_s;
      keep_r  <= keep_s;
    end
  end

`ifdef STREAM_UPSIZE_FLUSH_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_r;

  // Idle timer for a partial beat; it saturates while a flush waits for FIFO space.
  always_ff @(posedge clk) begin
    if (!rst_n || accept_s || push_s || state_r != FILL) begin
      idle_cnt_r <= '0;
    end else if (idle_cnt_r != CNT_W'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt_r <= idle_cnt_r + CNT_W'(1);
    end
  end

  assign flush_s = (state_r == FILL) && (idle_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) && !full_s;
`else
  assign flush_s = 1'b0;
`endif

  stream_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (m_valid_o && m_ready_i),
    .wdata (push_data_s),
    .rdata (rdata_s),
    .count (fill_level_o),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_stream_upsize_pack.sv
// Scoreboard bench for stream_upsize_pack: directed packets, stall/reset cases, then random traffic.
module tb_stream_upsize_pack;

  localparam int W = 8;
  localparam int R = 4;
  localparam int D = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [W-1:0]        s_data;
  logic                s_last;
  logic                s_valid;
  logic                s_ready;
  logic [R-1:0][W-1:0] m_data;
  logic [R-1:0]        m_keep;
  logic                m_last;
  logic                m_valid;
  logic                m_ready;
  logic [2:0]          fill;

  typedef struct {
    logic [R*W-1:0] data;
    logic [R-1:0]   keep;
    logic           last;
  } exp_beat_t;

  exp_beat_t    exp_q[$];
  logic [W-1:0] part_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_beats = 0;
  bit           rand_ready = 1'b0;

  stream_upsize_pack #(
    .T_DATA_WIDTH   (W),
    .T_DATA_RATIO   (R),
    .OUT_DEPTH      (D),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data_i     (s_data),
    .s_last_i     (s_last),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .m_data_o     (m_data),
    .m_keep_o     (m_keep),
    .m_last_o     (m_last),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .fill_level_o (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: words gather in order; a beat closes at R words or on last.
  task automatic close_beat(input logic last);
    exp_beat_t b;
    b.data = '0;
    b.keep = '0;
    for (int i = 0; i < part_q.size(); i++) begin
      b.data[i*W +: W] = part_q[i];
      b.keep[i] = 1'b1;
    end
    b.last = last;
    exp_q.push_back(b);
    part_q.delete();
  endtask

  task automatic model_word(input logic [W-1:0] d, input logic l);
    part_q.push_back(d);
    if (part_q.size() == R || l) close_beat(l);
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int waited = 0;
    bit ok = 1'b0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    while (!ok && waited <= 300) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) model_word(d, l);
    else chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every output handshake; check hold during stalls.
  logic [R*W-1:0] prev_data;
  logic [R-1:0]   prev_keep;
  logic           prev_last;
  bit             prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_beat_t b;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(prev_data));
        chk("hold_keep_last", 64'({m_keep, m_last}), 64'({prev_keep, prev_last}));
      end
      if (m_valid && m_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_data), 64'hDEAD_0000_0000_0000);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", 64'(m_data), 64'(b.data));
          chk("beat_keep", 64'(m_keep), 64'(b.keep));
          chk("beat_last", 64'(m_last), 64'(b.last));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_keep = m_keep;
      prev_last = m_last;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats0;
    bit seen;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_keep", 64'(m_keep), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;

    // Two full beats, the second ending the packet.
    for (int i = 1; i <= 8; i++) send_word(W'(i), (i == 8));
    wait_drain();

    // Short packet: partial beat, visible right after the closing handshake.
    send_word(8'hA0, 1'b0);
    send_word(8'hA1, 1'b0);
    send_word(8'hA2, 1'b1);
    @(negedge clk);
    chk("latency_valid", 64'(m_valid), 64'd1);
    wait_drain();

    send_word(8'h5C, 1'b1);
    wait_drain();

    // Downstream stall fills the FIFO, then drains.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_word(W'(8'h10 + i), 1'b0);
    @(negedge clk);
    chk("full_fill", 64'(fill), 64'd4);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("prepop_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("postpop_s_ready", 64'(s_ready), 64'd1);
    chk("postpop_fill", 64'(fill), 64'd3);
    wait_drain();

    // Reset mid-beat discards the partial words.
    send_word(8'h21, 1'b0);
    send_word(8'h22, 1'b0);
    rst_n = 1'b0;
    part_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_fill", 64'(fill), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    beats0 = n_beats;
    for (int i = 0; i < 4; i++) send_word(W'(8'h31 + i), 1'b0);
    wait_drain();
    chk("post_reset_beats", 64'(n_beats - beats0), 64'd1);

    // Idle partial beat: flushed only when the timeout feature is built in.
    send_word(8'h41, 1'b0);
    send_word(8'h42, 1'b0);
`ifdef STREAM_UPSIZE_FLUSH_EN
    close_beat(1'b0);
    repeat (24) @(negedge clk);
    wait_drain();
`else
    seen = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    chk("no_flush", 64'(seen), 64'd0);
    @(posedge clk); #1;
`endif

    // Random traffic with random downstream back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int gap;
      send_word(W'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    send_word(8'hEE, 1'b1);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("end_fill", 64'(fill), 64'd0);
    chk("end_s_ready", 64'(s_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
